// File: rtl/led_breathe.sv
// Breathing LED stage: turns raw blink on/off levels into PWM fades.
// Optional square-law brightness curve: define LED_BREATHE_GAMMA_EN.
module led_breathe #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                led_in,
    input  logic                enable,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS-1:0] MAX_M1 = MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] ONE    = 1;
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RISE,
        ST_ON,
        ST_FALL
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic [SW-1:0]       r_step_cnt;
    logic [SW-1:0]       w_step_nxt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_led_out;
    logic                w_led_nxt;
    logic                w_edge;
    logic                w_rise;
    logic                w_fall;
    logic                w_ramping;
    logic                w_step_done;
    logic [PWM_BITS-1:0] w_duty_eff;

    // Two-flop synchroniser plus a history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= led_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Edge classification and ramp-step strobe
    always_comb begin
        w_edge      = r_s2 ^ r_s3;
        w_rise      = w_edge & r_s2;
        w_fall      = w_edge & ~r_s2;
        w_ramping   = (r_state == ST_RISE) || (r_state == ST_FALL);
        w_step_done = w_ramping && (r_step_cnt == STEP_LAST);
    end

    // State, duty and prescaler registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_duty     <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_step_cnt <= w_step_nxt;
        end
    end

    // Next-state: a step completes in the old direction, then an edge
    // reverses the ramp from wherever duty ended up
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_step_nxt  = '0;
        if (!enable) begin
            w_state_nxt = r_s2 ? ST_ON : ST_OFF;
            w_duty_nxt  = r_s2 ? MAX : '0;
        end else begin
            unique case (r_state)
                ST_OFF: begin
                    if (w_rise) begin
                        w_state_nxt = ST_RISE;
                    end
                end
                ST_RISE: begin
                    if (w_step_done) begin
                        if (r_duty >= MAX_M1) begin
                            w_duty_nxt  = MAX;
                            w_state_nxt = ST_ON;
                        end else begin
                            w_duty_nxt = r_duty + 1'b1;
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + 1'b1;
                    end
                    if (w_fall) begin
                        w_state_nxt = ST_FALL;
                        w_step_nxt  = '0;
                    end
                end
                ST_ON: begin
                    if (w_fall) begin
                        w_state_nxt = ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (w_step_done) begin
                        if (r_duty <= ONE) begin
                            w_duty_nxt  = '0;
                            w_state_nxt = ST_OFF;
                        end else begin
                            w_duty_nxt = r_duty - 1'b1;
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + 1'b1;
                    end
                    if (w_rise) begin
                        w_state_nxt = ST_RISE;
                        w_step_nxt  = '0;
                    end
                end
            endcase
        end
    end

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_duty_wide;
    logic [2*PWM_BITS-1:0] w_duty_sq;

    // Square-law brightness; full scale kept fully lit
    always_comb begin
        w_duty_wide = {{PWM_BITS{1'b0}}, r_duty};
        w_duty_sq   = w_duty_wide * w_duty_wide;
        if (r_duty == MAX) begin
            w_duty_eff = MAX;
        end else begin
            w_duty_eff = PWM_BITS'(w_duty_sq >> PWM_BITS);
        end
    end
`else
    // Linear brightness
    always_comb begin
        w_duty_eff = r_duty;
    end
`endif

    // Free-running PWM counter, 0..MAX-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else if (r_pwm_cnt == MAX_M1) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // PWM compare, or plain level in bypass
    always_comb begin
        w_led_nxt = enable ? (r_pwm_cnt < w_duty_eff) : r_s2;
    end

    // Registered LED pin drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_out <= 1'b0;
        end else begin
            r_led_out <= w_led_nxt;
        end
    end

    assign led_out = r_led_out;
    assign duty    = r_duty;
    assign busy    = w_ramping;

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe: closed-form ramp model checked every cycle,
// plus directed literal checks of latency, ramps, reversal, PWM, bypass.
module tb_led_breathe;

    localparam int PW   = 4;
    localparam int DIV  = 3;
    localparam int MAXV = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          led_in = 1'b0;
    logic          enable = 1'b1;
    logic          led_out;
    logic [PW-1:0] duty;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    led_breathe #(
        .PWM_BITS(PW),
        .STEP_DIV(DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .led_in (led_in),
        .enable (enable),
        .led_out(led_out),
        .duty   (duty),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, got, exp, $time);
        end
    endtask

    function automatic int eff(input int d);
`ifdef LED_BREATHE_GAMMA_EN
        if (d == MAXV) return MAXV;
        return (d * d) >> PW;
`else
        return d;
`endif
    endfunction

    // Model: ramp described by start duty, start edge and direction;
    // duty = start +/- floor(elapsed / DIV), clamped at the ends.
    int n       = 0;
    bit samp[$];
    int m_dir   = 0;
    int m_start = 0;
    int m_t0    = 0;
    int m_duty  = 0;
    bit m_led   = 1'b0;
    bit m_busy  = 1'b0;

    function automatic bit get(input int k);
        if (k < 1) return 1'b0;
        return samp[k-1];
    endfunction

    task automatic model_step();
        int nn, k, raw, d;
        bit lvl, prv;
        nn  = n + 1;
        lvl = get(nn - 2);
        prv = get(nn - 3);
        if (!enable) m_led = lvl;
        else m_led = (((nn - 1) % MAXV) < eff(m_duty));
        d = m_duty;
        if (!enable) begin
            m_dir = 0;
            d = lvl ? MAXV : 0;
        end else begin
            if (m_dir != 0) begin
                k   = (nn - m_t0) / DIV;
                raw = m_start + m_dir * k;
                if (k >= 1 && m_dir > 0 && raw >= MAXV) begin
                    d = MAXV;
                    m_dir = 0;
                end else if (k >= 1 && m_dir < 0 && raw <= 0) begin
                    d = 0;
                    m_dir = 0;
                end else begin
                    d = raw;
                end
            end
            if (lvl != prv) begin
                if (lvl && !(m_dir > 0) && !(m_dir == 0 && d == MAXV)) begin
                    m_dir = 1;
                    m_start = d;
                    m_t0 = nn;
                end else if (!lvl && !(m_dir < 0) && !(m_dir == 0 && d == 0)) begin
                    m_dir = -1;
                    m_start = d;
                    m_t0 = nn;
                end
            end
        end
        m_duty = d;
        m_busy = (m_dir != 0);
        samp.push_back(led_in);
        n = nn;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n = 0;
                samp.delete();
                m_dir = 0;
                m_start = 0;
                m_t0 = 0;
                m_duty = 0;
                m_led = 1'b0;
                m_busy = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("cyc_duty", duty, m_duty);
                chk("cyc_busy", busy, m_busy);
                chk("cyc_led", led_out, m_led);
            end
        end
    end

    task automatic wait_n(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int hi;
        wait_n(3);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_duty", duty, 0);
        chk("rst_busy", busy, 0);
        chk("rst_led", led_out, 0);

        // full rise
        led_in = 1'b1;
        wait_n(2);
        chk("rise_lat2", busy, 0);
        wait_n(1);
        chk("rise_enter", busy, 1);
        chk("rise_d0", duty, 0);
        wait_n(15);
        chk("rise_d5", duty, 5);
        wait_n(29);
        chk("rise_d14", duty, 14);
        chk("rise_busy", busy, 1);
        wait_n(1);
        chk("on_duty", duty, 15);
        chk("on_busy", busy, 0);
        wait_n(1);
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            hi += int'(led_out);
        end
        chk("on_pwm", hi, 15);

        // full fall
        led_in = 1'b0;
        wait_n(3);
        chk("fall_enter", busy, 1);
        chk("fall_d15", duty, 15);
        wait_n(45);
        chk("off_duty", duty, 0);
        chk("off_busy", busy, 0);
        wait_n(1);
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            hi += int'(led_out);
        end
        chk("off_pwm", hi, 0);

        // reversal at duty 7
        led_in = 1'b1;
        wait_n(3);
        chk("rev_rise", busy, 1);
        wait_n(19);
        led_in = 1'b0;
        wait_n(3);
        chk("rev_d7", duty, 7);
        chk("rev_busy", busy, 1);
        wait_n(3);
        chk("rev_d6", duty, 6);
        wait_n(17);
        chk("rev_d1", duty, 1);
        wait_n(1);
        chk("rev_off", duty, 0);
        chk("rev_off_busy", busy, 0);

        // freeze duty at 5 with rapid reversals, measure PWM
        led_in = 1'b1;
        wait_n(3);
        wait_n(14);
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) led_in = ~led_in;
            @(negedge clk);
            if (c >= 10 && c < 25) hi += int'(led_out);
        end
`ifdef LED_BREATHE_GAMMA_EN
        chk("hold_pwm", hi, 1);
`else
        chk("hold_pwm", hi, 5);
`endif
        chk("hold_duty", duty, 5);
        chk("hold_busy", busy, 1);
        wait_n(60);
        chk("hold_on", duty, 15);

        // bypass
        enable = 1'b0;
        wait_n(2);
        chk("byp_led1", led_out, 1);
        led_in = 1'b0;
        wait_n(2);
        chk("byp_lat2", led_out, 1);
        chk("byp_d15", duty, 15);
        wait_n(1);
        chk("byp_led0", led_out, 0);
        chk("byp_d0", duty, 0);
        chk("byp_busy", busy, 0);
        led_in = 1'b1;
        wait_n(2);
        chk("byp_lat2b", led_out, 0);
        wait_n(1);
        chk("byp_led1b", led_out, 1);
        chk("byp_d15b", duty, 15);
        enable = 1'b1;
        wait_n(5);
        chk("en_noramp", busy, 0);
        chk("en_d15", duty, 15);

        // reset mid-ramp
        led_in = 1'b0;
        wait_n(13);
        chk("mid_d12", duty, 12);
        #2 rst = 1'b1;
        led_in = 1'b1;
        #1;
        chk("arst_duty", duty, 0);
        chk("arst_busy", busy, 0);
        chk("arst_led", led_out, 0);
        wait_n(3);
        chk("hrst_duty", duty, 0);
        chk("hrst_led", led_out, 0);
        rst = 1'b0;
        wait_n(2);
        chk("post_lat2", busy, 0);
        wait_n(1);
        chk("post_rise", busy, 1);
        wait_n(50);
        chk("post_on", duty, 15);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_breathe.md
Name: led_breathe

Overview:
- Downstream stage of the blink LED generator: consumes its raw on/off `led` level and drives the physical LED pin.
- Each on/off transition becomes a smooth PWM brightness ramp ("breathing" fade) instead of a hard toggle.
- Sits between the blink output and the board LED pin, in the same single `clk` domain.

Parameters:
- PWM_BITS, 8: width of the duty and PWM counters; full scale MAX = 2^PWM_BITS - 1.
- STEP_DIV, 50000: clk cycles per one-LSB duty step (ramp prescaler), must be >= 1.

Ports:
- clk  input  1  system clock; all logic clocked on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- led_in  input  1  raw LED level from the blink stage; treated as asynchronous, synchronised internally.
- enable  input  1  1 = fade mode; 0 = bypass (led_out follows synchronised level).
- led_out  output  1  PWM drive to the LED pin.
- duty  output  PWM_BITS  current brightness value.
- busy  output  1  high while in RISE or FALL.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - synchroniser flops = 0; state = OFF; duty = 0; pwm_cnt = 0; step_cnt = 0.
  - led_out = 0; busy = 0.
- Input synchroniser:
  - led_in -> s1 -> s2 (two flops); s3 holds the previous s2.
  - Edge exists when s2 != s3.
  - Rise: s2 = 1. Fall: s2 = 0.
- State machine (states OFF, RISE, ON, FALL):
  - A led_in change reaches the state register on the 3rd rising clk edge after it is set up at the input.
  - OFF: rise -> RISE.
  - RISE: fall -> FALL. duty reaching MAX -> ON.
  - ON: fall -> FALL.
  - FALL: rise -> RISE. duty reaching 0 -> OFF.
- Ramp timing:
  - On entering RISE or FALL, step_cnt clears to 0.
  - step_cnt counts 0..STEP_DIV-1 while in RISE/FALL.
  - At STEP_DIV-1: step_cnt wraps to 0, and duty increments (RISE) or decrements (FALL) by 1.
  - Full ramp 0 -> MAX takes exactly MAX*STEP_DIV cycles after entering RISE.
  - In RISE, the step that makes duty == MAX moves the state to ON on the same edge. FALL -> OFF is symmetric at duty == 0.
- Saturation: duty never wraps. It is held at MAX in ON and at 0 in OFF.
- Mid-ramp reversal:
  - The ramp reverses from the current duty value with no jump.
  - step_cnt restarts at 0.
- Edge on the same cycle a step completes: the direction change wins. The step is still applied first, in the old direction.
- PWM:
  - pwm_cnt counts 0..MAX-1 and wraps, free running.
  - led_out is registered: led_out <= (pwm_cnt < duty_eff).
  - duty_eff = 0 gives constant 0; duty_eff = MAX gives constant 1.
  - One cycle of latency from duty_eff to led_out.
- enable = 0:
  - led_out <= s2 (registered).
  - State machine and duty are forced to track the level: s2 = 1 gives ON with duty = MAX; s2 = 0 gives OFF with duty = 0.
  - busy = 0.
- enable rising while in steady state: no ramp starts until the next edge.
- busy = 1 exactly when state is RISE or FALL.
- Reset mid-ramp: immediately OFF, duty 0, led_out 0. A high led_in after release produces no edge until it changes. Exception: s2 = 1 right after reset counts as a rise, since s3 resets to 0.

Optional Feature:
- Macro: LED_BREATHE_GAMMA_EN.
- Defined: duty_eff = (duty * duty) >> PWM_BITS, computed at 2*PWM_BITS width and truncated to PWM_BITS. duty == MAX is special-cased to duty_eff = MAX so the ON state is fully lit. This gives perceptual (square-law) brightness.
- Undefined: duty_eff = duty (linear). No multiplier is synthesised.

Test Plan (PWM_BITS=4, STEP_DIV=3, MAX=15, enable=1 unless stated):
- Reset: assert rst mid-run -> led_out=0, duty=0, busy=0 asynchronously; all hold while rst is high.
- Full rise: led_in 0->1 -> state RISE 3 edges later, busy=1; duty increments every 3 cycles; duty=15 and state ON after 45 cycles; busy=0; led_out constant 1.
- Full fall: from ON, led_in 1->0 -> duty decrements every 3 cycles; OFF with duty=0 after 45 cycles; led_out constant 0.
- Reversal: led_in rises, then falls when duty=7 -> duty goes 7,6,... with no jump; reaches OFF 21 cycles after entering FALL.
- PWM check: hold duty=5 (freeze by asserting edge pattern) -> led_out high exactly 5 of every 15 cycles; with LED_BREATHE_GAMMA_EN, duty=8 -> high 4 of 15.
- Bypass: enable=0, toggle led_in -> led_out follows the input 3 cycles later, busy stays 0, duty jumps 0<->15.
